// File: rtl/clk_sel_pkg.sv
// Shared types and constants for the clock-select scheduler.
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    DWELL
  } state_e;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  localparam int unsigned SWITCH_CNT_W = 16;

endpackage

// File: rtl/clk_sel_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_sel_scheduler.sv
// Schedules clock-source switches for a glitch-free two-clock mux with
// settle and dwell windows, acknowledging each requester once its source is live.
module clk_sel_scheduler
  import clk_sel_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MIN_DWELL     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_src,
  input  logic                    cfg_lock,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic                    mux_select,
  output logic                    cur_src,
  output logic                    busy,
  output logic [SWITCH_CNT_W-1:0] switch_cnt
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > MIN_DWELL) ? SETTLE_CYCLES : MIN_DWELL;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = (MIN_DWELL > 0) ? CNT_W'(MIN_DWELL - 1) : '0;

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    cur_q, cur_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      win_q, win_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SWITCH_CNT_W-1:0] swc_q, swc_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;

  // Under cfg_lock only same-source requests compete, so a locked-out switch
  // neither wins nor advances the pointer. A requester whose ack is on the
  // wire this cycle is still holding req_valid and must not be re-granted.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && !ack_q[i] && (!cfg_lock || (req_src[i] == cur_q));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req       (elig),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cur_d   = cur_q;
    ack_d   = '0;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    swc_d   = swc_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (req_src[gnt_idx] == cur_q) begin
            ack_d = gnt;
          end else begin
            sel_d   = req_src[gnt_idx] ? SRC_CLK1 : SRC_CLK0;
            cnt_d   = SETTLE_LOAD;
            win_d   = gnt;
            state_d = SWITCH;
          end
        end
      end
      SWITCH: begin
        if (cnt_q == '0) begin
          ack_d = win_q;
          cur_d = sel_q;
          swc_d = (swc_q == '1) ? swc_q : swc_q + 1'b1;
          if (MIN_DWELL == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = DWELL_LOAD;
            state_d = DWELL;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SRC_CLK0;
      cur_q   <= SRC_CLK0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      swc_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      swc_q   <= swc_d;
    end
  end

  assign req_ack    = ack_q;
  assign mux_select = sel_q;
  assign cur_src    = cur_q;
  assign busy       = busy_q;
  assign switch_cnt = swc_q;

endmodule

// File: tb/tb_clk_sel_scheduler.sv
// Directed bench for clk_sel_scheduler: default build plus a SETTLE=1/DWELL=0 build.
module tb_clk_sel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_src;
  logic        cfg_lock;
  logic [3:0]  req_ack;
  logic        mux_select, cur_src, busy;
  logic [15:0] switch_cnt;

  logic        f_rst;
  logic [3:0]  f_req_valid, f_req_src;
  logic        f_cfg_lock;
  logic [3:0]  f_req_ack;
  logic        f_mux_select, f_cur_src, f_busy;
  logic [15:0] f_switch_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  clk_sel_scheduler #(
    .NUM_REQ       (4),
    .SETTLE_CYCLES (16),
    .MIN_DWELL     (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_src    (req_src),
    .cfg_lock   (cfg_lock),
    .req_ack    (req_ack),
    .mux_select (mux_select),
    .cur_src    (cur_src),
    .busy       (busy),
    .switch_cnt (switch_cnt)
  );

  clk_sel_scheduler #(
    .NUM_REQ       (4),
    .SETTLE_CYCLES (1),
    .MIN_DWELL     (0)
  ) dut_fast (
    .clk        (clk),
    .rst        (f_rst),
    .req_valid  (f_req_valid),
    .req_src    (f_req_src),
    .cfg_lock   (f_cfg_lock),
    .req_ack    (f_req_ack),
    .mux_select (f_mux_select),
    .cur_src    (f_cur_src),
    .busy       (f_busy),
    .switch_cnt (f_switch_cnt)
  );

  // Protocol and invariant monitors, sampled on the posedge before state updates.
  logic [3:0] prev_valid, f_prev_valid;
  logic       prev_rst, f_prev_rst;
  initial begin
    prev_valid = '0; f_prev_valid = '0; prev_rst = 1'b1; f_prev_rst = 1'b1;
  end
  always @(posedge clk) begin
    if (!rst && !prev_rst) begin
      assert ((prev_valid & ~req_valid & ~req_ack) == '0)
        else $error("protocol violation: req_valid dropped before ack");
      assert ($onehot0(req_ack)) else $error("req_ack not one-hot: %b", req_ack);
      assert (busy || (cur_src == mux_select)) else $error("cur_src differs from mux_select while idle");
    end
    if (!f_rst && !f_prev_rst) begin
      assert ((f_prev_valid & ~f_req_valid & ~f_req_ack) == '0)
        else $error("protocol violation on fast build");
      assert ($onehot0(f_req_ack)) else $error("fast req_ack not one-hot: %b", f_req_ack);
    end
    prev_valid   <= req_valid;
    prev_rst     <= rst;
    f_prev_valid <= f_req_valid;
    f_prev_rst   <= f_rst;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_src = '0; cfg_lock = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int max_cycles, output int waited, output logic [3:0] seen);
    waited = 0;
    seen   = '0;
    while (waited < max_cycles && seen == '0) begin
      tick();
      waited++;
      seen = req_ack;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_src = '0; cfg_lock = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({mux_select, cur_src, busy, req_ack, switch_cnt} !== 23'd0) begin
      $display("FAIL reset_state: got sel=%b cur=%b busy=%b ack=%b cnt=%0d, want all zero",
               mux_select, cur_src, busy, req_ack, switch_cnt);
    end else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_switch();
    do_reset();
    req_valid = 4'b0001; req_src = 4'b0001;
    tick();
    total_cnt++;
    if (mux_select !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL single_sel: got sel=%b busy=%b, want 1 1", mux_select, busy);
    end else pass_cnt++;
    for (int i = 0; i < 15; i++) tick();
    total_cnt++;
    if (req_ack !== 4'b0000 || cur_src !== 1'b0) begin
      $display("FAIL single_early: got ack=%b cur=%b at +15, want 0000 0", req_ack, cur_src);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (req_ack !== 4'b0001 || cur_src !== 1'b1 || switch_cnt !== 16'd1 || busy !== 1'b1) begin
      $display("FAIL single_ack: got ack=%b cur=%b cnt=%0d busy=%b, want 0001 1 1 1",
               req_ack, cur_src, switch_cnt, busy);
    end else pass_cnt++;
    req_valid = '0;
    for (int i = 0; i < 31; i++) tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL single_dwell_end: got busy=%b, want 1", busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || req_ack !== 4'b0000) begin
      $display("FAIL single_idle: got busy=%b ack=%b, want 0 0000", busy, req_ack);
    end else pass_cnt++;
  endtask

  task automatic test_same_src();
    do_reset();
    req_valid = 4'b0010; req_src = 4'b0000;
    tick();
    total_cnt++;
    if (req_ack !== 4'b0010 || mux_select !== 1'b0 || busy !== 1'b0 || switch_cnt !== 16'd0) begin
      $display("FAIL same_src_ack: got ack=%b sel=%b busy=%b cnt=%0d, want 0010 0 0 0",
               req_ack, mux_select, busy, switch_cnt);
    end else pass_cnt++;
    req_valid = '0;
    tick();
    total_cnt++;
    if (req_ack !== 4'b0000) $display("FAIL same_src_pulse: got ack=%b, want 0000", req_ack);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int         waited;
    logic [3:0] seen;
    int         exp_wait [4] = '{1, 17, 49, 49};
    logic [3:0] exp_ack  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    req_valid = 4'b1111; req_src = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_ack(200, waited, seen);
      total_cnt++;
      if (seen !== exp_ack[k] || waited != exp_wait[k]) begin
        $display("FAIL b2b_grant%0d: got ack=%b after %0d cycles, want %b after %0d",
                 k, seen, waited, exp_ack[k], exp_wait[k]);
      end else pass_cnt++;
      req_valid = req_valid & ~seen;
      if (seen == '0) req_valid = '0;
    end
    total_cnt++;
    if (switch_cnt !== 16'd3 || cur_src !== 1'b1 || mux_select !== 1'b1) begin
      $display("FAIL b2b_final: got cnt=%0d cur=%b sel=%b, want 3 1 1", switch_cnt, cur_src, mux_select);
    end else pass_cnt++;
  endtask

  task automatic test_cfg_lock();
    int         waited;
    logic [3:0] seen;
    do_reset();
    cfg_lock = 1'b1; req_valid = 4'b0101; req_src = 4'b0001;
    tick();
    total_cnt++;
    if (req_ack !== 4'b0100 || mux_select !== 1'b0) begin
      $display("FAIL lock_same_src: got ack=%b sel=%b, want 0100 0", req_ack, mux_select);
    end else pass_cnt++;
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (req_ack !== 4'b0000 || mux_select !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL lock_hold: got ack=%b sel=%b busy=%b, want 0000 0 0", req_ack, mux_select, busy);
    end else pass_cnt++;
    cfg_lock = 1'b0;
    tick();
    total_cnt++;
    if (mux_select !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL lock_release: got sel=%b busy=%b, want 1 1", mux_select, busy);
    end else pass_cnt++;
    wait_ack(100, waited, seen);
    total_cnt++;
    if (seen !== 4'b0001 || waited != 16) begin
      $display("FAIL lock_ack: got ack=%b after %0d, want 0001 after 16", seen, waited);
    end else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid_switch();
    int         waited;
    logic [3:0] seen;
    logic [3:0] acc;
    do_reset();
    req_valid = 4'b0001; req_src = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (mux_select !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL rst_mid_pre: got sel=%b busy=%b, want 1 1", mux_select, busy);
    end else pass_cnt++;
    rst = 1'b1; req_valid = '0;
    tick();
    total_cnt++;
    if (mux_select !== 1'b0 || cur_src !== 1'b0 || busy !== 1'b0 || req_ack !== 4'b0000) begin
      $display("FAIL rst_mid_abort: got sel=%b cur=%b busy=%b ack=%b, want 0 0 0 0000",
               mux_select, cur_src, busy, req_ack);
    end else pass_cnt++;
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc = acc | req_ack;
    end
    total_cnt++;
    if (acc !== 4'b0000) $display("FAIL rst_mid_noack: got ack=%b, want 0000", acc);
    else pass_cnt++;
    req_valid = 4'b0001;
    wait_ack(100, waited, seen);
    total_cnt++;
    if (seen !== 4'b0001 || waited != 17 || switch_cnt !== 16'd1 || cur_src !== 1'b1) begin
      $display("FAIL rst_mid_retry: got ack=%b after %0d cnt=%0d cur=%b, want 0001 after 17 1 1",
               seen, waited, switch_cnt, cur_src);
    end else pass_cnt++;
    req_valid = '0;
  endtask

  task automatic test_fast_build();
    f_rst = 1'b1; f_req_valid = '0; f_req_src = '0; f_cfg_lock = 1'b0;
    tick(); tick();
    f_rst = 1'b0;
    f_req_valid = 4'b0011; f_req_src = 4'b0001;
    tick();
    total_cnt++;
    if (f_mux_select !== 1'b1 || f_req_ack !== 4'b0000) begin
      $display("FAIL fast_sel1: got sel=%b ack=%b, want 1 0000", f_mux_select, f_req_ack);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (f_req_ack !== 4'b0001 || f_cur_src !== 1'b1) begin
      $display("FAIL fast_ack0: got ack=%b cur=%b, want 0001 1", f_req_ack, f_cur_src);
    end else pass_cnt++;
    f_req_valid = 4'b0010;
    tick();
    total_cnt++;
    if (f_mux_select !== 1'b0 || f_req_ack !== 4'b0000 || f_busy !== 1'b1) begin
      $display("FAIL fast_sel0: got sel=%b ack=%b busy=%b, want 0 0000 1", f_mux_select, f_req_ack, f_busy);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (f_req_ack !== 4'b0010 || f_cur_src !== 1'b0 || f_switch_cnt !== 16'd2) begin
      $display("FAIL fast_ack1: got ack=%b cur=%b cnt=%0d, want 0010 0 2", f_req_ack, f_cur_src, f_switch_cnt);
    end else pass_cnt++;
    f_req_valid = '0;
    tick();
    total_cnt++;
    if (f_busy !== 1'b0 || f_req_ack !== 4'b0000) begin
      $display("FAIL fast_idle: got busy=%b ack=%b, want 0 0000", f_busy, f_req_ack);
    end else pass_cnt++;
  endtask

  initial begin
    f_rst = 1'b1; f_req_valid = '0; f_req_src = '0; f_cfg_lock = 1'b0;
    test_reset();
    test_single_switch();
    test_same_src();
    test_back_to_back();
    test_cfg_lock();
    test_reset_mid_switch();
    test_fast_build();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
